// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
//   wb_req_t     : one register write (address + data)
//   fifo_entry_t : buffered memory-path write with arbitration age and WAW kill flag
//   PC_ADDR      : destination that is routed to the PC write port
package regfile_wb_arbiter_pkg;

    localparam logic [3:0]  PC_ADDR = 4'hF;
    localparam int unsigned AGE_W   = 4;

    typedef struct packed {
        logic [3:0]  wa;
        logic [31:0] wd;
    } wb_req_t;

    typedef struct packed {
        wb_req_t          req;
        logic [AGE_W-1:0] age;
        logic             kill;
    } fifo_entry_t;

    function automatic logic [15:0] onehot16(input logic [3:0] a);
        logic [15:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: circular buffer for memory-path writebacks.
//   push/push_req : enqueue at tail (age=0)
//   pop           : drop head
//   age_inc       : head lost arbitration this cycle (saturates at AGE_MAX)
//   kill_en/wa    : mark every entry with matching address as killed,
//                   including the one pushed in the same cycle
//   head/head_valid/full : head entry and occupancy status
//   addr_vec/live_vec    : per-slot address and occupied-and-not-killed flags
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned AGE_MAX = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  wb_req_t            push_req,
    input  logic               pop,
    input  logic               age_inc,
    input  logic               kill_en,
    input  logic [3:0]         kill_wa,
    output fifo_entry_t        head,
    output logic               head_valid,
    output logic               full,
    output logic [DEPTH*4-1:0] addr_vec,
    output logic [DEPTH-1:0]   live_vec
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PW'(i)] <= '0;
            end
        end else begin
            // Stale slots may also be marked; live_vec masks them by occupancy
            // and a push rewrites the whole slot.
            if (kill_en) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (mem[PW'(i)].req.wa == kill_wa) begin
                        mem[PW'(i)].kill <= 1'b1;
                    end
                end
            end
            if (age_inc && mem[rd_ptr].age != AGE_W'(AGE_MAX)) begin
                mem[rd_ptr].age <= mem[rd_ptr].age + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= '{req: push_req, age: '0,
                                 kill: kill_en && (push_req.wa == kill_wa)};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);
    assign full       = (count == (PW+1)'(DEPTH));

    always_comb begin
        logic [PW-1:0] off;
        off      = '0;
        addr_vec = '0;
        live_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off                = PW'(i) - rd_ptr;
            addr_vec[i*4 +: 4] = mem[PW'(i)].req.wa;
            live_vec[i]        = ({1'b0, off} < count) && !mem[PW'(i)].kill;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the ALU and memory/multiply writeback paths onto
// the register file write port, redirects R15 to the PC, and reports pending
// writes for RAW-hazard stalls.
//   alu_valid/alu_ready/alu_wa/alu_wd : single-cycle ALU result
//   mem_valid/mem_ready/mem_wa/mem_wd : buffered variable-latency result
//   we3/wa3/wd3                       : registered register-file write
//   pc_we/pc_wd                       : registered PC write (destination 15)
//   pend_mask                         : destinations buffered or in output reg
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned AGE_MAX    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_wa,
    input  logic [31:0] alu_wd,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wa,
    input  logic [31:0] mem_wd,
    output logic        we3,
    output logic [3:0]  wa3,
    output logic [31:0] wd3,
    output logic        pc_we,
    output logic [31:0] pc_wd,
    output logic [15:0] pend_mask
);

    fifo_entry_t               head;
    logic                      head_valid;
    logic                      full;
    logic [FIFO_DEPTH*4-1:0]   addr_vec;
    logic [FIFO_DEPTH-1:0]     live_vec;

    logic    head_live;
    logic    force_head;
    logic    alu_fire;
    logic    head_retire;
    logic    fifo_pop;
    logic    win_valid;
    wb_req_t win_req;

    assign head_live   = head_valid && !head.kill;
    assign force_head  = head_live && (head.age == AGE_W'(AGE_MAX));
    assign alu_ready   = !force_head;
    assign mem_ready   = !full;
    assign alu_fire    = alu_valid && alu_ready;
    assign head_retire = head_live && (force_head || !alu_valid);
    // A killed head leaves without using the write slot.
    assign fifo_pop    = head_retire || (head_valid && head.kill);
    assign win_valid   = alu_fire || head_retire;

    always_comb begin
        win_req = head.req;
        if (alu_fire) begin
            win_req = '{wa: alu_wa, wd: alu_wd};
        end
    end

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .AGE_MAX (AGE_MAX)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (mem_valid && mem_ready),
        .push_req   ('{wa: mem_wa, wd: mem_wd}),
        .pop        (fifo_pop),
        .age_inc    (head_live && !head_retire),
        .kill_en    (alu_fire),
        .kill_wa    (alu_wa),
        .head       (head),
        .head_valid (head_valid),
        .full       (full),
        .addr_vec   (addr_vec),
        .live_vec   (live_vec)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we3   <= 1'b0;
            wa3   <= '0;
            wd3   <= '0;
            pc_we <= 1'b0;
            pc_wd <= '0;
        end else begin
            we3   <= win_valid && (win_req.wa != PC_ADDR);
            pc_we <= win_valid && (win_req.wa == PC_ADDR);
            if (win_valid && win_req.wa != PC_ADDR) begin
                wa3 <= win_req.wa;
                wd3 <= win_req.wd;
            end
            if (win_valid && win_req.wa == PC_ADDR) begin
                pc_wd <= win_req.wd;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (live_vec[i]) begin
                pend_mask = pend_mask | onehot16(addr_vec[i*4 +: 4]);
            end
        end
        if (we3) begin
            pend_mask = pend_mask | onehot16(wa3);
        end
        if (pc_we) begin
            pend_mask[15] = 1'b1;
        end
    end

endmodule
